// File: rtl/cp0_exception_unit.sv
// MEM-stage coprocessor 0: CP0 registers, Count/Compare timer, and precise
// exception/interrupt arbitration that produces a flush request and redirect PC.
module cp0_exception_unit #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallM,
  input  logic [31:0] PCM,
  input  logic        DelaySlotM,
  input  logic        CP0WriteM,
  input  logic [4:0]  WriteAddrM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  ReadAddrM,
  output logic [31:0] ReadDataM,
  input  logic        SyscallM,
  input  logic        BreakM,
  input  logic        ReserveM,
  input  logic        EretM,
  input  logic        OverflowM,
  input  logic        AdelIfM,
  input  logic        AdelM,
  input  logic        AdesM,
  input  logic [31:0] BadAddrM,
  input  logic [5:0]  Int,
  output logic        ExceptionM,
  output logic [31:0] ExcTargetM,
  output logic [31:0] StatusO,
  output logic [31:0] CauseO,
  output logic [31:0] EPCO
);

  localparam logic [4:0]  ADDR_BADVADDR = 5'd8;
  localparam logic [4:0]  ADDR_COUNT    = 5'd9;
  localparam logic [4:0]  ADDR_COMPARE  = 5'd11;
  localparam logic [4:0]  ADDR_STATUS   = 5'd12;
  localparam logic [4:0]  ADDR_CAUSE    = 5'd13;
  localparam logic [4:0]  ADDR_EPC      = 5'd14;
  localparam logic [31:0] STATUS_WMASK  = 32'h0000_FF03;

  logic [31:0] status_q, status_d, cause_q, cause_d, epc_q, epc_d;
  logic [31:0] count_q, count_d, compare_q, compare_d, badvaddr_q, badvaddr_d;
  logic        tick_q, tick_d, timer_q, timer_d;

  logic        int_pending, exc_valid, is_eret, set_bad, commit;
  logic        take_exc, take_eret, wr_en;
  logic [4:0]  exc_code;
  logic [31:0] bad_val;

  // Fixed-priority arbitration; eret is a redirect without an exception code.
  always_comb begin
    int_pending = status_q[0] & ~status_q[1] & (|(cause_q[15:8] & status_q[15:8]));
    exc_valid   = 1'b1;
    is_eret     = 1'b0;
    exc_code    = 5'h00;
    set_bad     = 1'b0;
    bad_val     = 32'h0;
    if (int_pending)    exc_code = 5'h00;
    else if (AdelIfM)   begin exc_code = 5'h04; set_bad = 1'b1; bad_val = PCM; end
    else if (ReserveM)  exc_code = 5'h0A;
    else if (OverflowM) exc_code = 5'h0C;
    else if (SyscallM)  exc_code = 5'h08;
    else if (BreakM)    exc_code = 5'h09;
    else if (AdelM)     begin exc_code = 5'h04; set_bad = 1'b1; bad_val = BadAddrM; end
    else if (AdesM)     begin exc_code = 5'h05; set_bad = 1'b1; bad_val = BadAddrM; end
    else if (EretM)     begin exc_valid = 1'b0; is_eret = 1'b1; end
    else                exc_valid = 1'b0;

    commit     = ~rst & ~StallM;
    take_exc   = commit & exc_valid;
    take_eret  = commit & is_eret;
    ExceptionM = take_exc | take_eret;
    ExcTargetM = take_eret ? epc_q : (take_exc ? EXC_VECTOR : 32'h0);
    wr_en      = commit & CP0WriteM & ~ExceptionM;
  end

  always_comb begin
    tick_d     = ~tick_q;
    count_d    = tick_q ? count_q + 32'd1 : count_q;
    compare_d  = compare_q;
    timer_d    = timer_q;
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;

    if (wr_en && WriteAddrM == ADDR_COUNT) begin
      count_d = WriteDataM;
      tick_d  = 1'b0;
    end
    // A Compare write acknowledges the timer even if the new value matches.
    if (wr_en && WriteAddrM == ADDR_COMPARE) begin
      compare_d = WriteDataM;
      timer_d   = 1'b0;
    end else if (count_d == compare_q) begin
      timer_d = 1'b1;
    end

    cause_d[15:10] = {Int[5] | timer_q, Int[4:0]};
    if (wr_en && WriteAddrM == ADDR_STATUS)
      status_d = (status_q & ~STATUS_WMASK) | (WriteDataM & STATUS_WMASK);
    if (wr_en && WriteAddrM == ADDR_CAUSE) cause_d[9:8] = WriteDataM[9:8];
    if (wr_en && WriteAddrM == ADDR_EPC)   epc_d = WriteDataM;

    if (take_exc) begin
      cause_d[6:2] = exc_code;
      status_d[1]  = 1'b1;
      if (!status_q[1]) begin
        epc_d       = DelaySlotM ? PCM - 32'd4 : PCM;
        cause_d[31] = DelaySlotM;
      end
      if (set_bad) badvaddr_d = bad_val;
    end
    if (take_eret) status_d[1] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q   <= STATUS_RST;
      cause_q    <= 32'h0;
      epc_q      <= 32'h0;
      count_q    <= 32'h0;
      compare_q  <= 32'h0;
      badvaddr_q <= 32'h0;
      tick_q     <= 1'b0;
      timer_q    <= 1'b0;
    end else begin
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      badvaddr_q <= badvaddr_d;
      tick_q     <= tick_d;
      timer_q    <= timer_d;
    end
  end

  always_comb begin
    case (ReadAddrM)
      ADDR_BADVADDR: ReadDataM = badvaddr_q;
      ADDR_COUNT:    ReadDataM = count_q;
      ADDR_COMPARE:  ReadDataM = compare_q;
      ADDR_STATUS:   ReadDataM = status_q;
      ADDR_CAUSE:    ReadDataM = cause_q;
      ADDR_EPC:      ReadDataM = epc_q;
      default:       ReadDataM = 32'h0;
    endcase
  end

  assign StatusO = status_q;
  assign CauseO  = cause_q;
  assign EPCO    = epc_q;

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Bench for cp0_exception_unit: directed scenarios plus randomized traffic,
// all checked against a register-level behavioural model of CP0.
module tb_cp0_exception_unit;

  localparam logic [31:0] VEC      = 32'hBFC0_0380;
  localparam logic [31:0] STAT_RST = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallM, DelaySlotM, CP0WriteM;
  logic [31:0] PCM, WriteDataM, BadAddrM;
  logic [4:0]  WriteAddrM, ReadAddrM;
  logic [31:0] ReadDataM;
  logic        SyscallM, BreakM, ReserveM, EretM, OverflowM, AdelIfM, AdelM, AdesM;
  logic [5:0]  Int;
  logic        ExceptionM;
  logic [31:0] ExcTargetM, StatusO, CauseO, EPCO;

  int checks = 0;
  int errors = 0;

  cp0_exception_unit dut (
    .clk(clk), .rst(rst), .StallM(StallM), .PCM(PCM), .DelaySlotM(DelaySlotM),
    .CP0WriteM(CP0WriteM), .WriteAddrM(WriteAddrM), .WriteDataM(WriteDataM),
    .ReadAddrM(ReadAddrM), .ReadDataM(ReadDataM), .SyscallM(SyscallM),
    .BreakM(BreakM), .ReserveM(ReserveM), .EretM(EretM), .OverflowM(OverflowM),
    .AdelIfM(AdelIfM), .AdelM(AdelM), .AdesM(AdesM), .BadAddrM(BadAddrM),
    .Int(Int), .ExceptionM(ExceptionM), .ExcTargetM(ExcTargetM),
    .StatusO(StatusO), .CauseO(CauseO), .EPCO(EPCO)
  );

  always #5 clk = ~clk;

  // Reference model: architectural registers; Count is base + elapsed/2.
  logic [31:0] m_status, m_cause, m_epc, m_compare, m_badv, m_cnt_base;
  logic        m_timer;
  int          m_cnt_elapsed;
  int          exc_codes[9] = '{0, 4, 10, 12, 8, 9, 4, 5, 0};

  function automatic logic [31:0] m_count();
    return m_cnt_base + 32'(m_cnt_elapsed / 2);
  endfunction

  function automatic logic m_int_pending();
    return m_status[0] && !m_status[1] && ((m_cause[15:8] & m_status[15:8]) != 8'h0);
  endfunction

  // Index into the priority list (0=interrupt .. 8=eret), -1 when idle.
  function automatic int m_sel();
    logic fl[9];
    fl[0] = m_int_pending(); fl[1] = AdelIfM; fl[2] = ReserveM; fl[3] = OverflowM;
    fl[4] = SyscallM; fl[5] = BreakM; fl[6] = AdelM; fl[7] = AdesM; fl[8] = EretM;
    for (int i = 0; i < 9; i++) if (fl[i]) return i;
    return -1;
  endfunction

  function automatic logic m_exp_exc();
    return !rst && !StallM && (m_sel() >= 0);
  endfunction

  function automatic logic [31:0] m_exp_target();
    if (!m_exp_exc()) return 32'h0;
    return (m_sel() == 8) ? m_epc : VEC;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:  return m_badv;
      5'd9:  return m_count();
      5'd11: return m_compare;
      5'd12: return m_status;
      5'd13: return m_cause;
      5'd14: return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_status = STAT_RST; m_cause = 0; m_epc = 0; m_compare = 0; m_badv = 0;
    m_cnt_base = 0; m_cnt_elapsed = 0; m_timer = 0;
  endtask

  task automatic model_clock();
    int sel;
    logic exc, eret, wr, old_timer, old_exl;
    sel       = m_sel();
    exc       = !StallM && sel >= 0 && sel < 8;
    eret      = !StallM && sel == 8;
    wr        = !StallM && CP0WriteM && !exc && !eret;
    old_timer = m_timer;
    old_exl   = m_status[1];
    m_cnt_elapsed++;
    if (wr && WriteAddrM == 5'd9) begin m_cnt_base = WriteDataM; m_cnt_elapsed = 0; end
    if (wr && WriteAddrM == 5'd11) begin m_compare = WriteDataM; m_timer = 0; end
    else if (m_count() == m_compare) m_timer = 1;
    m_cause[15:10] = {Int[5] | old_timer, Int[4:0]};
    if (wr && WriteAddrM == 5'd12) m_status = (m_status & ~32'hFF03) | (WriteDataM & 32'hFF03);
    if (wr && WriteAddrM == 5'd13) m_cause[9:8] = WriteDataM[9:8];
    if (wr && WriteAddrM == 5'd14) m_epc = WriteDataM;
    if (exc) begin
      m_cause[6:2] = 5'(exc_codes[sel]);
      m_status[1]  = 1'b1;
      if (!old_exl) begin
        m_epc       = DelaySlotM ? PCM - 32'd4 : PCM;
        m_cause[31] = DelaySlotM;
      end
      if (sel == 1) m_badv = PCM;
      if (sel == 6 || sel == 7) m_badv = BadAddrM;
    end
    if (eret) m_status[1] = 1'b0;
  endtask

  task automatic tick();
    if (rst) model_reset();
    else model_clock();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    StallM = 0; PCM = 0; DelaySlotM = 0; CP0WriteM = 0; WriteAddrM = 0; WriteDataM = 0;
    ReadAddrM = 0; SyscallM = 0; BreakM = 0; ReserveM = 0; EretM = 0; OverflowM = 0;
    AdelIfM = 0; AdelM = 0; AdesM = 0; BadAddrM = 0; Int = 0;
  endtask

  task automatic do_mtc0(input logic [4:0] a, input logic [31:0] d);
    CP0WriteM = 1; WriteAddrM = a; WriteDataM = d;
    tick();
    CP0WriteM = 0; WriteAddrM = 0; WriteDataM = 0;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs(); SyscallM = 1;
    #1;
    checks++; if (ExceptionM !== 1'b0) begin errors++; $display("FAIL reset_exc got %0h exp 0", ExceptionM); end
    tick(); tick();
    checks++; if (ExceptionM !== 1'b0) begin errors++; $display("FAIL reset_exc2 got %0h exp 0", ExceptionM); end
    rst = 0; SyscallM = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (ExceptionM !== 1'b0) begin errors++; $display("FAIL idle_exc cyc %0d got %0h exp 0", i, ExceptionM); end
      tick();
    end
    ReadAddrM = 5'd9; #1;
    checks++; if (ReadDataM !== 32'd5) begin errors++; $display("FAIL reset_count got %h exp %h", ReadDataM, 32'd5); end
    checks++; if (StatusO !== STAT_RST) begin errors++; $display("FAIL reset_status got %h exp %h", StatusO, STAT_RST); end
    checks++; if (EPCO !== 32'h0) begin errors++; $display("FAIL reset_epc got %h exp 0", EPCO); end
    ReadAddrM = 0;
  endtask

  task automatic test_syscall();
    PCM = 32'h8000_0100; DelaySlotM = 1; SyscallM = 1; #1;
    checks++; if (ExceptionM !== 1'b1) begin errors++; $display("FAIL sys_exc got %0h exp 1", ExceptionM); end
    checks++; if (ExcTargetM !== VEC) begin errors++; $display("FAIL sys_target got %h exp %h", ExcTargetM, VEC); end
    tick(); clear_inputs();
    checks++; if (EPCO !== 32'h8000_00FC) begin errors++; $display("FAIL sys_epc got %h exp 800000fc", EPCO); end
    checks++; if (CauseO[31] !== 1'b1) begin errors++; $display("FAIL sys_bd got %0h exp 1", CauseO[31]); end
    checks++; if (CauseO[6:2] !== 5'h08) begin errors++; $display("FAIL sys_code got %h exp 08", CauseO[6:2]); end
    checks++; if (StatusO[1] !== 1'b1) begin errors++; $display("FAIL sys_exl got %0h exp 1", StatusO[1]); end
  endtask

  task automatic test_eret();
    EretM = 1; CP0WriteM = 1; WriteAddrM = 5'd14; WriteDataM = 32'hDEAD_BEEF; #1;
    checks++; if (ExceptionM !== 1'b1) begin errors++; $display("FAIL eret_exc got %0h exp 1", ExceptionM); end
    checks++; if (ExcTargetM !== 32'h8000_00FC) begin errors++; $display("FAIL eret_target got %h exp 800000fc", ExcTargetM); end
    tick(); clear_inputs();
    checks++; if (StatusO[1] !== 1'b0) begin errors++; $display("FAIL eret_exl got %0h exp 0", StatusO[1]); end
    checks++; if (EPCO !== 32'h8000_00FC) begin errors++; $display("FAIL eret_mtc0_suppress got %h exp 800000fc", EPCO); end
  endtask

  task automatic test_timer();
    logic taken;
    taken = 0;
    do_mtc0(5'd11, 32'd3);
    do_mtc0(5'd9, 32'd0);
    do_mtc0(5'd12, 32'h0000_8001);
    ReadAddrM = 5'd9;
    for (int i = 0; i < 12 && !taken; i++) begin
      #1;
      checks++; if (ExceptionM !== m_exp_exc()) begin errors++; $display("FAIL timer_exc cyc %0d got %0h exp %0h", i, ExceptionM, m_exp_exc()); end
      checks++; if (ReadDataM !== m_count()) begin errors++; $display("FAIL timer_count cyc %0d got %h exp %h", i, ReadDataM, m_count()); end
      taken = m_exp_exc();
      tick();
    end
    checks++; if (CauseO[6:2] !== 5'h00 || !taken) begin errors++; $display("FAIL timer_int_code got %h taken %0d exp 00", CauseO[6:2], taken); end
    checks++; if (CauseO[15] !== 1'b1) begin errors++; $display("FAIL timer_ip7 got %0h exp 1", CauseO[15]); end
    checks++; if (StatusO[1] !== 1'b1) begin errors++; $display("FAIL timer_exl got %0h exp 1", StatusO[1]); end
    do_mtc0(5'd11, 32'd100);
    tick();
    checks++; if (CauseO[15] !== 1'b0) begin errors++; $display("FAIL timer_ip7_clear got %0h exp 0", CauseO[15]); end
    ReadAddrM = 0;
  endtask

  task automatic test_priority();
    AdesM = 1; OverflowM = 1; BadAddrM = 32'h1234_5671; #1;
    checks++; if (ExcTargetM !== VEC) begin errors++; $display("FAIL prio_target got %h exp %h", ExcTargetM, VEC); end
    tick(); clear_inputs();
    ReadAddrM = 5'd8; #1;
    checks++; if (CauseO[6:2] !== 5'h0C) begin errors++; $display("FAIL prio_code got %h exp 0c", CauseO[6:2]); end
    checks++; if (ReadDataM !== 32'h0) begin errors++; $display("FAIL prio_badv got %h exp 0", ReadDataM); end
    AdesM = 1; BadAddrM = 32'h1234_5671;
    tick(); clear_inputs();
    ReadAddrM = 5'd8; #1;
    checks++; if (CauseO[6:2] !== 5'h05) begin errors++; $display("FAIL ades_code got %h exp 05", CauseO[6:2]); end
    checks++; if (ReadDataM !== 32'h1234_5671) begin errors++; $display("FAIL ades_badv got %h exp 12345671", ReadDataM); end
    ReadAddrM = 0;
  endtask

  task automatic test_stall();
    StallM = 1; BreakM = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ExceptionM !== 1'b0) begin errors++; $display("FAIL stall_exc cyc %0d got %0h exp 0", i, ExceptionM); end
      tick();
      checks++; if (CauseO[6:2] !== 5'h05) begin errors++; $display("FAIL stall_nocommit cyc %0d got %h exp 05", i, CauseO[6:2]); end
    end
    StallM = 0; #1;
    checks++; if (ExceptionM !== 1'b1) begin errors++; $display("FAIL unstall_exc got %0h exp 1", ExceptionM); end
    tick(); clear_inputs();
    checks++; if (CauseO[6:2] !== 5'h09) begin errors++; $display("FAIL unstall_code got %h exp 09", CauseO[6:2]); end
  endtask

  task automatic test_count_wrap();
    ReadAddrM = 5'd9;
    do_mtc0(5'd9, 32'hFFFF_FFFF);
    #1;
    checks++; if (ReadDataM !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_load got %h exp ffffffff", ReadDataM); end
    tick(); tick();
    checks++; if (ReadDataM !== 32'h0) begin errors++; $display("FAIL wrap_zero got %h exp 0", ReadDataM); end
    ReadAddrM = 0;
  endtask

  task automatic test_random();
    logic [4:0] addrs[7];
    addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};
    for (int i = 0; i < 400; i++) begin
      StallM     = ($urandom_range(0, 7) == 0);
      PCM        = $urandom & 32'hFFFF_FFFC;
      DelaySlotM = $urandom_range(0, 1) == 1;
      AdelIfM    = ($urandom_range(0, 20) == 0);
      ReserveM   = ($urandom_range(0, 20) == 0);
      OverflowM  = ($urandom_range(0, 20) == 0);
      SyscallM   = ($urandom_range(0, 20) == 0);
      BreakM     = ($urandom_range(0, 20) == 0);
      AdelM      = ($urandom_range(0, 20) == 0);
      AdesM      = ($urandom_range(0, 20) == 0);
      EretM      = ($urandom_range(0, 6) == 0);
      BadAddrM   = $urandom;
      Int        = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0;
      CP0WriteM  = ($urandom_range(0, 2) == 0);
      WriteAddrM = addrs[$urandom_range(0, 6)];
      if (WriteAddrM == 5'd0) WriteAddrM = 5'($urandom);
      WriteDataM = (WriteAddrM == 5'd11) ? m_count() + 32'($urandom_range(0, 6)) : $urandom;
      ReadAddrM  = addrs[$urandom_range(0, 6)];
      #1;
      checks++; if (ExceptionM !== m_exp_exc()) begin errors++; $display("FAIL rnd_exc cyc %0d got %0h exp %0h", i, ExceptionM, m_exp_exc()); end
      checks++; if (ExcTargetM !== m_exp_target()) begin errors++; $display("FAIL rnd_target cyc %0d got %h exp %h", i, ExcTargetM, m_exp_target()); end
      checks++; if (ReadDataM !== m_read(ReadAddrM)) begin errors++; $display("FAIL rnd_read cyc %0d addr %0d got %h exp %h", i, ReadAddrM, ReadDataM, m_read(ReadAddrM)); end
      tick();
      checks++; if (StatusO !== m_status) begin errors++; $display("FAIL rnd_status cyc %0d got %h exp %h", i, StatusO, m_status); end
      checks++; if (CauseO !== m_cause) begin errors++; $display("FAIL rnd_cause cyc %0d got %h exp %h", i, CauseO, m_cause); end
      checks++; if (EPCO !== m_epc) begin errors++; $display("FAIL rnd_epc cyc %0d got %h exp %h", i, EPCO, m_epc); end
    end
    clear_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_syscall();
    test_eret();
    test_timer();
    test_priority();
    test_stall();
    test_count_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
